// File: rtl/avalon_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package  : avalon_arb_pkg                                        |
// | Purpose  : Shared types and constants for the two-host Avalon    |
// |            arbiter.                                              |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
package avalon_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    WBURST = 2'd2,
    RDATA  = 2'd3
  } arb_state_t;

  // 0 = host h0, 1 = host h1
  typedef logic owner_t;

  localparam owner_t c_OWNER_H0 = 1'b0;
  localparam owner_t c_OWNER_H1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/avalon_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Interface : avalon_if                                            |
// | Purpose   : Avalon-MM bundle with bursting and pipelined reads.  |
// | Revision  : 1.0                                                  |
// +------------------------------------------------------------------+
interface avalon_if #(
  parameter int DATA_BYTES   = 4,
  parameter int BURSTCOUNT_W = 6,
  parameter int ADDR_W       = 32
);
  logic [ADDR_W-1:0]         address;
  logic [DATA_BYTES-1:0]     byteenable;
  logic                      read;
  logic                      write;
  logic [DATA_BYTES*8-1:0]   writedata;
  logic [BURSTCOUNT_W-1:0]   burstcount;
  logic                      waitrequest;
  logic [DATA_BYTES*8-1:0]   readdata;
  logic                      readdatavalid;

  modport host (
    output address, byteenable, read, write, writedata, burstcount,
    input  waitrequest, readdata, readdatavalid
  );

  modport agent (
    input  address, byteenable, read, write, writedata, burstcount,
    output waitrequest, readdata, readdatavalid
  );
endinterface
`default_nettype wire

// File: rtl/avalon_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : avalon_rr_arbiter                                     |
// | Purpose  : Combinational two-way round-robin pick. On a tie the  |
// |            host that did not win the previous tie is chosen.     |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module avalon_rr_arbiter
  import avalon_arb_pkg::*;
(
  input  logic   i_req0,
  input  logic   i_req1,
  input  owner_t i_last,
  output logic   o_valid,
  output logic   o_tie,
  output owner_t o_owner
);

  // Grant selection: single requester wins outright, ties alternate
  always_comb begin
    o_valid = i_req0 | i_req1;
    o_tie   = i_req0 & i_req1;
    if (o_tie) begin
      o_owner = ~i_last;
    end else if (i_req1) begin
      o_owner = c_OWNER_H1;
    end else begin
      o_owner = c_OWNER_H0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/avalon_arbiter2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : avalon_arbiter2                                       |
// | Purpose  : Shares one Avalon-MM agent between two hosts. The     |
// |            grant is held across a whole write burst or until all |
// |            read beats return, so bursts never interleave.        |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module avalon_arbiter2
  import avalon_arb_pkg::*;
#(
  parameter int DATA_BYTES   = 4,
  parameter int BURSTCOUNT_W = 6
) (
  input logic     clk,
  input logic     reset,
  avalon_if.agent h0,
  avalon_if.agent h1,
  avalon_if.host  m
);

  localparam int c_DATA_W = DATA_BYTES * 8;
  localparam logic [BURSTCOUNT_W-1:0] c_BC_ONE = BURSTCOUNT_W'(1);

  arb_state_t              r_state, w_state_nxt;
  owner_t                  r_owner, w_owner_nxt;
  owner_t                  r_last,  w_last_nxt;
  logic [BURSTCOUNT_W-1:0] r_remaining, w_remaining_nxt;

  logic                    w_arb_valid, w_arb_tie;
  owner_t                  w_arb_owner;

  logic                    w_own_read, w_own_write;
  logic [BURSTCOUNT_W-1:0] w_own_bc, w_bc_eff, w_rdv_ext, w_rd_left;
  logic [c_DATA_W-1:0]     w_own_wdata;
  logic                    w_wr_acc, w_rd_acc;
  logic                    w_own_wait, w_own_rdv;

  avalon_rr_arbiter u_rr (
    .i_req0  (h0.read | h0.write),
    .i_req1  (h1.read | h1.write),
    .i_last  (r_last),
    .o_valid (w_arb_valid),
    .o_tie   (w_arb_tie),
    .o_owner (w_arb_owner)
  );

  // Owner-side request mux and acceptance decode
  always_comb begin
    w_own_read  = (r_owner == c_OWNER_H1) ? h1.read       : h0.read;
    w_own_write = (r_owner == c_OWNER_H1) ? h1.write      : h0.write;
    w_own_bc    = (r_owner == c_OWNER_H1) ? h1.burstcount : h0.burstcount;
    w_own_wdata = (r_owner == c_OWNER_H1) ? h1.writedata  : h0.writedata;
    // A zero burstcount is a single beat
    w_bc_eff    = (w_own_bc == '0) ? c_BC_ONE : w_own_bc;
    w_rdv_ext   = {{(BURSTCOUNT_W-1){1'b0}}, m.readdatavalid};
    // A data beat may arrive in the very cycle the read is accepted
    w_rd_left   = w_bc_eff - w_rdv_ext;
    w_wr_acc    = w_own_write & ~m.waitrequest;
    // Write wins if a host illegally raises both strobes
    w_rd_acc    = w_own_read & ~w_own_write & ~m.waitrequest;
  end

  // State, owner, tie history and beat counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_owner     <= c_OWNER_H0;
      r_last      <= c_OWNER_H1;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_last      <= w_last_nxt;
      r_remaining <= w_remaining_nxt;
    end
  end

  // Next-state logic; tie history only moves when both hosts contend
  always_comb begin
    w_state_nxt     = r_state;
    w_owner_nxt     = r_owner;
    w_last_nxt      = r_last;
    w_remaining_nxt = r_remaining;
    case (r_state)
      IDLE: begin
        if (w_arb_valid) begin
          w_state_nxt = GRANT;
          w_owner_nxt = w_arb_owner;
          if (w_arb_tie) begin
            w_last_nxt = w_arb_owner;
          end
        end
      end
      GRANT: begin
        if (w_wr_acc) begin
          if (w_bc_eff == c_BC_ONE) begin
            w_state_nxt     = IDLE;
            w_remaining_nxt = '0;
          end else begin
            w_state_nxt     = WBURST;
            w_remaining_nxt = w_bc_eff - c_BC_ONE;
          end
        end else if (w_rd_acc) begin
          w_remaining_nxt = w_rd_left;
          w_state_nxt     = (w_rd_left == '0) ? IDLE : RDATA;
        end else if (!w_own_read && !w_own_write) begin
          // Owner withdrew its request; release rather than stall
          w_state_nxt = IDLE;
        end
      end
      WBURST: begin
        if (w_wr_acc) begin
          w_remaining_nxt = r_remaining - c_BC_ONE;
          if (r_remaining == c_BC_ONE) begin
            w_state_nxt = IDLE;
          end
        end
      end
      RDATA: begin
        if (m.readdatavalid) begin
          w_remaining_nxt = r_remaining - c_BC_ONE;
          if (r_remaining == c_BC_ONE) begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Downstream forwarding and per-host handshake demux
  always_comb begin
    m.address    = (r_owner == c_OWNER_H1) ? h1.address    : h0.address;
    m.byteenable = (r_owner == c_OWNER_H1) ? h1.byteenable : h0.byteenable;
    m.writedata  = w_own_wdata;
    m.burstcount = w_own_bc;
    m.read       = 1'b0;
    m.write      = 1'b0;
    w_own_wait   = 1'b1;
    w_own_rdv    = 1'b0;
    case (r_state)
      GRANT: begin
        m.read     = w_own_read & ~w_own_write;
        m.write    = w_own_write;
        w_own_wait = m.waitrequest;
        w_own_rdv  = m.readdatavalid;
      end
      WBURST: begin
        m.write    = w_own_write;
        w_own_wait = m.waitrequest;
      end
      RDATA: begin
        w_own_rdv  = m.readdatavalid;
      end
      default: begin
      end
    endcase
    h0.readdata      = m.readdata;
    h1.readdata      = m.readdata;
    h0.waitrequest   = (r_owner == c_OWNER_H0) ? w_own_wait : 1'b1;
    h1.waitrequest   = (r_owner == c_OWNER_H1) ? w_own_wait : 1'b1;
    h0.readdatavalid = (r_owner == c_OWNER_H0) ? w_own_rdv  : 1'b0;
    h1.readdatavalid = (r_owner == c_OWNER_H1) ? w_own_rdv  : 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_avalon_arbiter2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_avalon_arbiter2                                    |
// | Purpose  : Directed self-checking bench for avalon_arbiter2.     |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module tb_avalon_arbiter2;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  avalon_if #(.DATA_BYTES(4), .BURSTCOUNT_W(6)) h0_if ();
  avalon_if #(.DATA_BYTES(4), .BURSTCOUNT_W(6)) h1_if ();
  avalon_if #(.DATA_BYTES(4), .BURSTCOUNT_W(6)) m_if ();

  avalon_arbiter2 #(.DATA_BYTES(4), .BURSTCOUNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .h0    (h0_if),
    .h1    (h1_if),
    .m     (m_if)
  );

  always #5 clk = ~clk;

  task automatic idle_all();
    h0_if.read = 1'b0; h0_if.write = 1'b0; h0_if.address = '0;
    h0_if.byteenable = 4'hF; h0_if.writedata = '0; h0_if.burstcount = 6'd1;
    h1_if.read = 1'b0; h1_if.write = 1'b0; h1_if.address = '0;
    h1_if.byteenable = 4'hF; h1_if.writedata = '0; h1_if.burstcount = 6'd1;
    m_if.waitrequest = 1'b0; m_if.readdata = '0; m_if.readdatavalid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_all();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_all();
    h0_if.write = 1'b1; h1_if.read = 1'b1;
    m_if.readdatavalid = 1'b1;
    @(negedge clk);
    checks++; if (m_if.read !== 1'b0) begin failures++; $display("FAIL rst_m_read got=%b exp=0", m_if.read); end
    checks++; if (m_if.write !== 1'b0) begin failures++; $display("FAIL rst_m_write got=%b exp=0", m_if.write); end
    checks++; if (h0_if.waitrequest !== 1'b1) begin failures++; $display("FAIL rst_h0_wait got=%b exp=1", h0_if.waitrequest); end
    checks++; if (h1_if.waitrequest !== 1'b1) begin failures++; $display("FAIL rst_h1_wait got=%b exp=1", h1_if.waitrequest); end
    checks++; if (h0_if.readdatavalid !== 1'b0) begin failures++; $display("FAIL rst_h0_rdv got=%b exp=0", h0_if.readdatavalid); end
    checks++; if (h1_if.readdatavalid !== 1'b0) begin failures++; $display("FAIL rst_h1_rdv got=%b exp=0", h1_if.readdatavalid); end
  endtask

  task automatic test_tie();
    do_reset();
    h0_if.write = 1'b1; h0_if.address = 32'h100; h0_if.writedata = 32'h11;
    h1_if.write = 1'b1; h1_if.address = 32'h200; h1_if.writedata = 32'h22;
    @(negedge clk);
    checks++; if (m_if.write !== 1'b0) begin failures++; $display("FAIL tie_idle_write got=%b exp=0", m_if.write); end
    next_cycle();
    @(negedge clk);
    checks++; if (m_if.write !== 1'b1 || m_if.address !== 32'h100) begin failures++; $display("FAIL tie1_first got=%b/%h exp=1/100", m_if.write, m_if.address); end
    checks++; if (h1_if.waitrequest !== 1'b1) begin failures++; $display("FAIL tie1_h1_wait got=%b exp=1", h1_if.waitrequest); end
    next_cycle();
    h0_if.write = 1'b0;
    @(negedge clk);
    checks++; if (m_if.write !== 1'b0) begin failures++; $display("FAIL tie1_gap got=%b exp=0", m_if.write); end
    next_cycle();
    @(negedge clk);
    checks++; if (m_if.write !== 1'b1 || m_if.address !== 32'h200 || m_if.writedata !== 32'h22) begin failures++; $display("FAIL tie1_second got=%b/%h/%h exp=1/200/22", m_if.write, m_if.address, m_if.writedata); end
    next_cycle();
    h1_if.write = 1'b0;
    // second tie: h1 did not win the previous tie's history, so it goes first
    h0_if.write = 1'b1; h0_if.address = 32'h104;
    h1_if.write = 1'b1; h1_if.address = 32'h204;
    next_cycle();
    @(negedge clk);
    checks++; if (m_if.write !== 1'b1 || m_if.address !== 32'h204) begin failures++; $display("FAIL tie2_first got=%b/%h exp=1/204", m_if.write, m_if.address); end
    checks++; if (h0_if.waitrequest !== 1'b1) begin failures++; $display("FAIL tie2_h0_wait got=%b exp=1", h0_if.waitrequest); end
    next_cycle();
    h1_if.write = 1'b0;
    next_cycle();
    @(negedge clk);
    checks++; if (m_if.write !== 1'b1 || m_if.address !== 32'h104) begin failures++; $display("FAIL tie2_second got=%b/%h exp=1/104", m_if.write, m_if.address); end
    next_cycle();
    h0_if.write = 1'b0;
  endtask

  task automatic test_write_burst();
    int  m_beats = 0;
    int  h0_beats = 0;
    int  wait_viol = 0;
    bit  h1_acc = 1'b0;
    bit  acc0, acc1;
    do_reset();
    h0_if.write = 1'b1; h0_if.address = 32'h300; h0_if.burstcount = 6'd4; h0_if.writedata = 32'hA0;
    for (int c = 0; c < 40; c++) begin
      m_if.waitrequest = ((c % 2) == 1);
      if (c == 2) begin
        h1_if.read = 1'b1; h1_if.address = 32'h500; h1_if.burstcount = 6'd1;
      end
      @(negedge clk);
      acc0 = h0_if.write && !h0_if.waitrequest;
      acc1 = h1_if.read && !h1_if.waitrequest;
      if (m_if.write && !m_if.waitrequest) begin
        checks++;
        if (m_if.address !== 32'h300 || m_if.writedata !== (32'hA0 + 32'(m_beats))) begin
          failures++; $display("FAIL wb_beat%0d got=%h/%h exp=300/%h", m_beats, m_if.address, m_if.writedata, 32'hA0 + 32'(m_beats));
        end
        m_beats++;
      end
      if (m_beats < 4 && h1_if.waitrequest !== 1'b1) wait_viol++;
      if (m_if.read && !m_if.waitrequest && !h1_acc) begin
        h1_acc = 1'b1;
        checks++;
        if (m_beats !== 4 || m_if.address !== 32'h500) begin failures++; $display("FAIL wb_h1_order got beats=%0d addr=%h exp=4/500", m_beats, m_if.address); end
      end
      next_cycle();
      if (acc0) begin
        h0_beats++;
        h0_if.writedata = h0_if.writedata + 32'h1;
        if (h0_beats == 4) h0_if.write = 1'b0;
      end
      if (acc1) begin
        h1_if.read = 1'b0;
        break;
      end
    end
    checks++; if (m_beats !== 4) begin failures++; $display("FAIL wb_beats got=%0d exp=4", m_beats); end
    checks++; if (h1_acc !== 1'b1) begin failures++; $display("FAIL wb_h1_granted got=%b exp=1", h1_acc); end
    checks++; if (wait_viol !== 0) begin failures++; $display("FAIL wb_h1_wait got=%0d exp=0", wait_viol); end
  endtask

  task automatic test_read_burst();
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int h1_cnt = 0;
    int h0_cnt = 0;
    do_reset();
    h1_if.read = 1'b1; h1_if.address = 32'h40; h1_if.burstcount = 6'd3;
    next_cycle();
    @(negedge clk);
    checks++; if (m_if.read !== 1'b1 || m_if.address !== 32'h40 || m_if.burstcount !== 6'd3) begin failures++; $display("FAIL rb_cmd got=%b/%h/%0d exp=1/40/3", m_if.read, m_if.address, m_if.burstcount); end
    checks++; if (h1_if.waitrequest !== 1'b0 || h0_if.waitrequest !== 1'b1) begin failures++; $display("FAIL rb_cmd_wait got=%b/%b exp=0/1", h1_if.waitrequest, h0_if.waitrequest); end
    next_cycle();
    h1_if.read = 1'b0;
    for (int k = 0; k < 6; k++) begin
      m_if.readdatavalid = pat[k];
      m_if.readdata = 32'hD00 + 32'(k);
      @(negedge clk);
      if (k == 0) begin
        checks++; if (m_if.read !== 1'b0 || h1_if.waitrequest !== 1'b1) begin failures++; $display("FAIL rb_rdata_block got=%b/%b exp=0/1", m_if.read, h1_if.waitrequest); end
      end
      if (h1_if.readdatavalid === 1'b1) begin
        h1_cnt++;
        checks++; if (h1_if.readdata !== 32'hD00 + 32'(k)) begin failures++; $display("FAIL rb_data got=%h exp=%h", h1_if.readdata, 32'hD00 + 32'(k)); end
      end
      if (h0_if.readdatavalid !== 1'b0) h0_cnt++;
      next_cycle();
    end
    checks++; if (h1_cnt !== 3) begin failures++; $display("FAIL rb_h1_pulses got=%0d exp=3", h1_cnt); end
    checks++; if (h0_cnt !== 0) begin failures++; $display("FAIL rb_h0_pulses got=%0d exp=0", h0_cnt); end
    m_if.readdatavalid = 1'b1;
    @(negedge clk);
    checks++; if (h1_if.readdatavalid !== 1'b0) begin failures++; $display("FAIL rb_stray_idle got=%b exp=0", h1_if.readdatavalid); end
    next_cycle();
    m_if.readdatavalid = 1'b0;
  endtask

  task automatic test_zero_latency();
    do_reset();
    h0_if.read = 1'b1; h0_if.address = 32'h80; h0_if.burstcount = 6'd1;
    m_if.readdatavalid = 1'b1; m_if.readdata = 32'h1234;
    @(negedge clk);
    checks++; if (h0_if.readdatavalid !== 1'b0) begin failures++; $display("FAIL zl_idle_rdv got=%b exp=0", h0_if.readdatavalid); end
    next_cycle();
    @(negedge clk);
    checks++; if (m_if.read !== 1'b1 || h0_if.readdatavalid !== 1'b1 || h0_if.readdata !== 32'h1234) begin failures++; $display("FAIL zl_grant got=%b/%b/%h exp=1/1/1234", m_if.read, h0_if.readdatavalid, h0_if.readdata); end
    checks++; if (h1_if.readdatavalid !== 1'b0) begin failures++; $display("FAIL zl_h1_rdv got=%b exp=0", h1_if.readdatavalid); end
    next_cycle();
    h0_if.read = 1'b0; m_if.readdatavalid = 1'b0;
    h0_if.write = 1'b1; h0_if.address = 32'h84;
    @(negedge clk);
    checks++; if (h0_if.waitrequest !== 1'b1 || m_if.write !== 1'b0) begin failures++; $display("FAIL zl_idle got=%b/%b exp=1/0", h0_if.waitrequest, m_if.write); end
    next_cycle();
    @(negedge clk);
    checks++; if (m_if.write !== 1'b1 || m_if.address !== 32'h84) begin failures++; $display("FAIL zl_next_grant got=%b/%h exp=1/84", m_if.write, m_if.address); end
    next_cycle();
    h0_if.write = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    h1_if.read = 1'b1; h1_if.address = 32'h10; h1_if.burstcount = 6'd4;
    next_cycle();
    next_cycle();
    h1_if.read = 1'b0;
    m_if.readdatavalid = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++; if (h1_if.readdatavalid !== 1'b1) begin failures++; $display("FAIL rm_pre got=%b exp=1", h1_if.readdatavalid); end
    #1 reset = 1'b1;
    #1;
    checks++; if (h1_if.readdatavalid !== 1'b0 || h0_if.readdatavalid !== 1'b0) begin failures++; $display("FAIL rm_async_rdv got=%b/%b exp=0/0", h0_if.readdatavalid, h1_if.readdatavalid); end
    checks++; if (h1_if.waitrequest !== 1'b1 || h0_if.waitrequest !== 1'b1) begin failures++; $display("FAIL rm_async_wait got=%b/%b exp=1/1", h0_if.waitrequest, h1_if.waitrequest); end
    checks++; if (m_if.read !== 1'b0 || m_if.write !== 1'b0) begin failures++; $display("FAIL rm_async_m got=%b/%b exp=0/0", m_if.read, m_if.write); end
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (h1_if.readdatavalid !== 1'b0 || h0_if.readdatavalid !== 1'b0) begin failures++; $display("FAIL rm_late%0d got=%b/%b exp=0/0", k, h0_if.readdatavalid, h1_if.readdatavalid); end
      next_cycle();
    end
    m_if.readdatavalid = 1'b0;
  endtask

  task automatic test_bc_zero();
    do_reset();
    h0_if.write = 1'b1; h0_if.address = 32'h600; h0_if.burstcount = 6'd0; h0_if.writedata = 32'h55;
    next_cycle();
    @(negedge clk);
    checks++; if (m_if.write !== 1'b1 || m_if.address !== 32'h600) begin failures++; $display("FAIL bz_cmd got=%b/%h exp=1/600", m_if.write, m_if.address); end
    next_cycle();
    h0_if.write = 1'b0;
    h1_if.write = 1'b1; h1_if.address = 32'h700; h1_if.burstcount = 6'd1;
    @(negedge clk);
    checks++; if (h0_if.waitrequest !== 1'b1 || m_if.write !== 1'b0) begin failures++; $display("FAIL bz_idle got=%b/%b exp=1/0", h0_if.waitrequest, m_if.write); end
    next_cycle();
    @(negedge clk);
    checks++; if (m_if.write !== 1'b1 || m_if.address !== 32'h700) begin failures++; $display("FAIL bz_next got=%b/%h exp=1/700", m_if.write, m_if.address); end
    next_cycle();
    h1_if.write = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_all();
    test_reset();
    test_tie();
    test_write_burst();
    test_read_burst();
    test_zero_latency();
    test_reset_mid();
    test_bc_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/avalon_arbiter2.md
# avalon_arbiter2

Two-host to one-agent Avalon MM arbiter built on the `avalon_if` interface. It shares a single agent, such as an SDRAM controller or on-chip RAM port, between two RTL hosts using round-robin arbitration. A grant is held for a whole write burst, or for a read command until all of its burst data has returned, so bursts are never interleaved. Read data is routed back only to the host that issued the read.

## Interface
- `DATA_BYTES`, default 4: bytes per data word; must match all three interfaces.
- `BURSTCOUNT_W`, default 6: burstcount width; must match all three interfaces.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `h0`  `avalon_if.agent`  interface  host 0 request port; host 0 has priority on the first tie after reset.
- `h1`  `avalon_if.agent`  interface  host 1 request port.
- `m`  `avalon_if.host`  interface  shared downstream agent.

## Operation
- States:
  - IDLE: no owner.
  - GRANT: command phase of the owner.
  - WBURST: remaining write beats.
  - RDATA: waiting for read beats.
- IDLE:
  - A host is requesting when its `read` or `write` is 1.
  - If either host requests, register the owner and go to GRANT.
  - If both request, the host that is not `last` wins. Then `last` is set to the owner.
  - `m.read`, `m.write` = 0. Both hosts see `waitrequest` = 1 and `readdatavalid` = 0.
- GRANT:
  - `m.address`, `byteenable`, `read`, `write`, `writedata` and `burstcount` are driven combinationally from the owner.
  - Owner `waitrequest` = `m.waitrequest`. The non-owner sees `waitrequest` = 1.
  - Write accepted (`write && !m.waitrequest`):
    - If burstcount ≤ 1, go to IDLE.
    - Otherwise go to WBURST with remaining = burstcount−1.
  - Read accepted: go to RDATA with remaining = burstcount − (`m.readdatavalid` ? 1 : 0).
    - If that value is 0, go to IDLE.
  - Owner asserts neither `read` nor `write`: go to IDLE. This is a protocol violation and is tolerated.
- WBURST:
  - Same forwarding as GRANT.
  - Each accepted write decrements remaining. The accepted beat with remaining = 1 goes to IDLE.
  - The owner may deassert `write` between beats; the grant is held.
  - `read` from the owner is masked to 0.
- RDATA:
  - `m.read`, `m.write` = 0. The owner sees `waitrequest` = 1, so no pipelined commands are issued.
  - Each `m.readdatavalid` is routed to the owner only and decrements remaining. The last beat goes to IDLE.
- `readdata` is broadcast to both hosts. `readdatavalid` reaches the owner only, in GRANT or RDATA.
- A burstcount of 0 is treated as 1.
- Counter width is BURSTCOUNT_W. No value wraps, because the maximum load is 2^BURSTCOUNT_W−1.

## Timing
- Reset values:
  - state = IDLE, owner = 0, `last` = 1, remaining = 0.
  - `m.read` = `m.write` = 0.
  - `h0`/`h1` `waitrequest` = 1, `readdatavalid` = 0.
- Arbitration latency is one cycle: a request seen in IDLE at edge N is forwarded to `m` in cycle N+1.
- There is one idle cycle between consecutive grants. Back-to-back transfers by the same host also pass through IDLE.
- Reset asserted mid-burst returns the block to IDLE immediately. Late `m.readdatavalid` beats are then dropped, because no host is the owner.
- Simultaneous acceptance of the last write beat and a new request from the other host: the new request is granted one cycle later, from IDLE.

## Structure
- Package `avalon_arb_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, GRANT, WBURST, RDATA} arb_state_t`
  - `typedef logic owner_t` (0 = h0, 1 = h1)
- Sub-module `avalon_rr_arbiter`:
  - Purely combinational grant from two request bits plus `last`.
  - The `last` register lives in the parent.
- The parent contains the FSM, the remaining counter and the mux/demux.

## Test plan
- Tie: both hosts issue single writes (h0 addr 0x100, h1 addr 0x200) in the same cycle → `m` sees 0x100 first, then 0x200 two cycles later. A second tie grants h1 first.
- Write burst: h0 write with burstcount = 4 and agent `waitrequest` toggling; h1 requests during the burst → exactly 4 beats appear on `m` before any h1 access. h1 `waitrequest` stays 1 throughout.
- Read burst: h1 read with burstcount = 3 at 0x40, data returned with gaps → only h1 sees 3 `readdatavalid` pulses. h0 `readdatavalid` stays 0. IDLE is reached after the 3rd beat.
- Zero-latency agent: read with burstcount = 1 and `readdatavalid` in the acceptance cycle → direct GRANT→IDLE transition and no hang.
- Reset during RDATA with 2 beats outstanding → all outputs return to their reset values asynchronously. Post-reset `m.readdatavalid` pulses do not reach either host.
- burstcount = 0 write → treated as a single beat and the block returns to IDLE.
